// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronizes, debounces and edge-flags KEY/SW for the CPU IO read/write path
module io_input_conditioner #(
    parameter int DB_CYCLES = 3,
    parameter int KEY_W     = 4,
    parameter int SW_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KEY_W-1:0]  key_raw,
    input  logic [SW_W-1:0]   sw_raw,
    input  logic              sel,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [KEY_W-1:0]  key_db,
    output logic [SW_W-1:0]   sw_db,
    output logic              irq
);
    localparam int N = KEY_W + SW_W;
    localparam logic [N-1:0] INIT = {{SW_W{1'b0}}, {KEY_W{1'b1}}};
    localparam logic [8:0] SETTLE = 9'(DB_CYCLES + 2);
    logic [N-1:0]      sync1, sync2, stable, stable_nxt, chg;
    logic [N-1:0][7:0] cnt, cnt_nxt;
    logic [8:0]        settle_cnt;
    logic              settling;
    logic [KEY_W-1:0]  key_evt, key_set, key_clr;
    logic [SW_W-1:0]   sw_chg, sw_set, sw_clr;
    logic              hit_key, hit_sw, hit_evt, hit_chg;
    logic              unused_bits;

    assign settling = settle_cnt != SETTLE;

    always_comb begin
        stable_nxt = stable;
        cnt_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (settling)
                stable_nxt[i] = sync2[i];
            else if (sync2[i] != stable[i]) begin
                if (cnt[i] == 8'(DB_CYCLES - 1))
                    stable_nxt[i] = sync2[i];
                else
                    cnt_nxt[i] = cnt[i] + 8'd1;
            end
        end
    end

    // keys are active-low: a press is the stable bit falling from 1 to 0
    assign chg     = settling ? '0 : (stable ^ stable_nxt);
    assign key_set = chg[KEY_W-1:0] & stable[KEY_W-1:0];
    assign sw_set  = chg[N-1:KEY_W];

    assign hit_key = sel & addr[4];
    assign hit_sw  = sel & ~addr[4] & addr[5];
    assign hit_evt = sel & ~|addr[5:4] & addr[6];
    assign hit_chg = sel & ~|addr[6:4] & addr[7];
    assign key_clr = {KEY_W{we & hit_evt}} & wdata[KEY_W-1:0];
    assign sw_clr  = {SW_W{we & hit_chg}} & wdata[SW_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= INIT;
            sync2      <= INIT;
            stable     <= INIT;
            cnt        <= '0;
            settle_cnt <= '0;
            key_evt    <= '0;
            sw_chg     <= '0;
        end else begin
            sync1      <= {sw_raw, key_raw};
            sync2      <= sync1;
            stable     <= stable_nxt;
            cnt        <= cnt_nxt;
            settle_cnt <= settling ? settle_cnt + 9'd1 : settle_cnt;
            key_evt    <= (key_evt & ~key_clr) | key_set;
            sw_chg     <= (sw_chg & ~sw_clr) | sw_set;
        end
    end

    assign key_db = ~stable[KEY_W-1:0];
    assign sw_db  = stable[N-1:KEY_W];
    assign irq    = |key_evt | |sw_chg;

    assign rdata = hit_key ? 32'(key_db) :
                   hit_sw  ? 32'(sw_db)  :
                   hit_evt ? 32'(key_evt) :
                   hit_chg ? 32'(sw_chg) : 32'd0;

    assign unused_bits = &{1'b0, addr[31:8], addr[3:0], wdata[31:SW_W]};
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: scoreboard bench with a window-based debounce reference model
module tb_io_input_conditioner;
    localparam int DB = 3, KW = 4, SW = 10, N = KW + SW;
    localparam logic [N-1:0] INIT = {{SW{1'b0}}, {KW{1'b1}}};

    typedef struct packed {
        logic [KW-1:0] k;
        logic [SW-1:0] s;
        logic [31:0]   rd;
        logic          irq;
    } exp_t;

    logic          clk = 1'b1, reset = 1'b1, sel = 1'b0, we = 1'b0;
    logic [KW-1:0] key_raw = '1, key_db;
    logic [SW-1:0] sw_raw = '0, sw_db;
    logic [31:0]   addr = '0, wdata = '0, rdata;
    logic          irq;

    io_input_conditioner #(.DB_CYCLES(DB), .KEY_W(KW), .SW_W(SW)) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw), .sw_raw(sw_raw),
        .sel(sel), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .key_db(key_db), .sw_db(sw_db), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [N-1:0]  hist[$];
    logic [N-1:0]  m_st = INIT;
    logic [KW-1:0] m_kevt = '0;
    logic [SW-1:0] m_chg = '0;
    exp_t          q[$];
    int            errors = 0, checks = 0;
    logic [KW-1:0] kv = '1;
    logic [SW-1:0] sv = '0;

    // value the second synchronizer flop presents at the e-th edge after reset release
    function automatic logic [N-1:0] s2(int e);
        return e >= 3 ? hist[e-3] : INIT;
    endfunction

    function automatic int reg_of(logic s, logic [31:0] a);
        if (!s) return 0;
        if (a[4]) return 1;
        if (a[5]) return 2;
        if (a[6]) return 3;
        if (a[7]) return 4;
        return 0;
    endfunction

    function automatic exp_t expect_now();
        exp_t x;
        logic [KW-1:0] kd;
        kd = ~m_st[KW-1:0];
        x.k = kd;
        x.s = m_st[N-1:KW];
        x.irq = (m_kevt != 0) || (m_chg != 0);
        case (reg_of(sel, addr))
            1: x.rd = 32'(kd);
            2: x.rd = 32'(m_st[N-1:KW]);
            3: x.rd = 32'(m_kevt);
            4: x.rd = 32'(m_chg);
            default: x.rd = 32'd0;
        endcase
        return x;
    endfunction

    // a bit flips once DB consecutive post-settle samples all disagree with it
    task automatic model_edge();
        logic [N-1:0] old, chg, smp;
        logic [KW-1:0] kclr;
        logic [SW-1:0] sclr;
        logic ok;
        int e;
        hist.push_back({sw_raw, key_raw});
        e = hist.size();
        old = m_st;
        chg = '0;
        if (e <= DB + 2) m_st = s2(e);
        else begin
            for (int b = 0; b < N; b++) begin
                ok = (e - DB + 1 >= DB + 3);
                for (int j = 0; j < DB; j++) begin
                    smp = s2(e - j);
                    if (smp[b] == old[b]) ok = 1'b0;
                end
                if (ok) m_st[b] = ~old[b];
            end
            chg = old ^ m_st;
        end
        kclr = (we && reg_of(sel, addr) == 3) ? wdata[KW-1:0] : '0;
        sclr = (we && reg_of(sel, addr) == 4) ? wdata[SW-1:0] : '0;
        m_kevt = (m_kevt & ~kclr) | (chg[KW-1:0] & old[KW-1:0]);
        m_chg  = (m_chg & ~sclr) | chg[N-1:KW];
    endtask

    task automatic step(input logic rs, input logic sl, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        reset = rs; key_raw = kv; sw_raw = sv; sel = sl; we = w; addr = a; wdata = d;
        if (!rs) begin
            hist.delete();
            m_st = INIT; m_kevt = '0; m_chg = '0;
        end
        #0 q.push_back(expect_now());
        @(posedge clk);
        if (rs) model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                x = q.pop_front();
                chk("key_db", 32'(key_db), 32'(x.k));
                chk("sw_db", 32'(sw_db), 32'(x.s));
                chk("rdata", rdata, x.rd);
                chk("irq", 32'(irq), 32'(x.irq));
            end
        end
    end

    initial begin : stim
        logic [31:0] addrs [5];
        addrs = '{32'h110, 32'h120, 32'h140, 32'h180, 32'h100};
        #1;
        kv = 4'hF; sv = 10'h3FF;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        idle(8);
        for (int i = 0; i < 5; i++) step(1, 1, 0, addrs[i], 0);
        kv[2] = 1'b0;
        for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h140, 0);
        step(1, 1, 1, 32'h140, 32'h4);
        kv[1] = 1'b0; idle(2); kv[1] = 1'b1; idle(6);
        sv = 10'h000; idle(10);
        step(1, 1, 1, 32'h180, 32'h3FF);
        sv[9] = 1'b1; idle(10); sv[9] = 1'b0; idle(10);
        step(1, 1, 0, 32'h180, 0);
        step(1, 1, 1, 32'h180, 32'h200);
        step(1, 1, 0, 32'h180, 0);
        kv[0] = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h140, 0);
        step(1, 1, 1, 32'h140, 32'h1);
        step(1, 1, 0, 32'h140, 0);
        step(1, 1, 1, 32'h140, 32'h1);
        step(1, 1, 1, 32'h110, 32'hFFFF_FFFF);
        step(1, 1, 1, 32'h120, 32'hFFFF_FFFF);
        step(1, 1, 0, 32'h110, 0);
        sv[3] = 1'b1; idle(4);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h140, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, addrs[i % 4], 0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) kv[$urandom_range(0, KW - 1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) sv[$urandom_range(0, SW - 1)] ^= 1'b1;
            step($urandom_range(0, 399) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
                 addrs[$urandom_range(0, 4)], $urandom);
        end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
